// File: rtl/snn_pkg.sv
// Shared definitions for the spike encoder: default sizes, FSM state type,
// and the LFSR constants/step function used when SPIKE_ENC_LFSR_EN is defined.
package snn_pkg;

    localparam int N_PIX  = 5;
    localparam int PIX_W  = 8;
    localparam int STEP_W = 8;

    // Galois LFSR, taps 16,14,13,11, right-shifting form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } enc_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/spike_rate_cell.sv
// One spike lane. Holds the captured pixel and either a phase accumulator
// (default) or a 16-bit Galois LFSR (SPIKE_ENC_LFSR_EN). The spike is a pure
// function of registered state, so it is stable while the lane is not advanced.
module spike_rate_cell
    import snn_pkg::*;
#(
    parameter int W = 8
`ifdef SPIKE_ENC_LFSR_EN
    ,
    parameter logic [15:0] SEED = 16'hACE1
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         advance,
    input  logic [W-1:0] pix,
    output logic         spike
);

    logic [W-1:0] r_pix;

`ifdef SPIKE_ENC_LFSR_EN
    logic [15:0] r_lfsr;

    assign spike = (r_lfsr[W-1:0] < r_pix);

    // Capture pixel and reseed on load; step the LFSR once per transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix  <= '0;
            r_lfsr <= 16'h0000;
        end else if (load) begin
            r_pix  <= pix;
            r_lfsr <= SEED;
        end else if (advance) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end else begin
            r_lfsr <= r_lfsr;
        end
    end
`else
    logic [W-1:0] r_acc;
    logic [W:0]   w_sum;

    // Carry out of acc + pix marks a spike; the low bits wrap modulo 2^W
    assign w_sum = {1'b0, r_acc} + {1'b0, r_pix};
    assign spike = w_sum[W];

    // Capture pixel and clear phase on load; accumulate once per transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix <= '0;
            r_acc <= '0;
        end else if (load) begin
            r_pix <= pix;
            r_acc <= '0;
        end else if (advance) begin
            r_acc <= w_sum[W-1:0];
        end else begin
            r_acc <= r_acc;
        end
    end
`endif

endmodule

// File: rtl/spike_encoder.sv
// Rate-coding spike encoder: frame FSM (IDLE -> RUN -> FIN), timestep counter
// and valid/ready handshake around N_PIX spike_rate_cell lanes.
// Optional macro SPIKE_ENC_LFSR_EN selects stochastic LFSR coding per lane.
module spike_encoder
    import snn_pkg::*;
#(
    parameter int N_PIX  = snn_pkg::N_PIX,
    parameter int PIX_W  = snn_pkg::PIX_W,
    parameter int STEP_W = snn_pkg::STEP_W
`ifdef SPIKE_ENC_LFSR_EN
    ,
    parameter logic [15:0] LFSR_SEED = snn_pkg::LFSR_SEED
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N_PIX*PIX_W-1:0] pix_in,
    input  logic [STEP_W-1:0]      num_steps,
    output logic                   busy,
    output logic                   spike_valid,
    input  logic                   spike_ready,
    output logic [N_PIX-1:0]       spikes,
    output logic [STEP_W-1:0]      step_idx,
    output logic                   done
);

    enc_state_t          r_state;
    enc_state_t          w_state_nxt;
    logic [STEP_W-1:0]   r_steps;
    logic [STEP_W-1:0]   r_step_idx;
    logic                w_accept;
    logic                w_xfer;
    logic                w_last;
    logic [N_PIX-1:0]    w_spk;

    assign w_accept = (r_state == IDLE) && start && (num_steps != '0);
    assign w_xfer   = (r_state == RUN) && spike_ready;
    assign w_last   = (r_step_idx == (r_steps - STEP_W'(1)));

    // Frame sequencing; a zero-length request goes straight to FIN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (num_steps != '0) ? RUN : FIN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_xfer && w_last) begin
                    w_state_nxt = FIN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame length capture and timestep counter; the last step does not wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_steps    <= '0;
            r_step_idx <= '0;
        end else if (w_accept) begin
            r_steps    <= num_steps;
            r_step_idx <= '0;
        end else if (w_xfer && !w_last) begin
            r_step_idx <= r_step_idx + STEP_W'(1);
        end else begin
            r_step_idx <= r_step_idx;
        end
    end

    for (genvar i = 0; i < N_PIX; i++) begin : g_lane
        spike_rate_cell #(
            .W(PIX_W)
`ifdef SPIKE_ENC_LFSR_EN
            ,
            .SEED(LFSR_SEED ^ 16'(i + 1))
`endif
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (w_accept),
            .advance (w_xfer),
            .pix     (pix_in[PIX_W*i +: PIX_W]),
            .spike   (w_spk[i])
        );
    end

    // Outputs decode registered state only; spikes are masked outside RUN
    assign busy        = (r_state == RUN);
    assign spike_valid = (r_state == RUN);
    assign done        = (r_state == FIN);
    assign spikes      = (r_state == RUN) ? w_spk : '0;
    assign step_idx    = r_step_idx;

endmodule

// File: tb/tb_spike_encoder.sv
// Directed self-checking bench for spike_encoder (default accumulator coding).
module tb_spike_encoder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [39:0] pix_in;
    logic [7:0]  num_steps;
    logic        busy;
    logic        spike_valid;
    logic        spike_ready;
    logic [4:0]  spikes;
    logic [7:0]  step_idx;
    logic        done;

    int total = 0;
    int bad   = 0;

    // pixel4..pixel0 = 1,255,128,64,0
    localparam logic [39:0] PIX_A = {8'd1, 8'd255, 8'd128, 8'd64, 8'd0};

    // Hand-derived vectors for pix=(0,64,128,255,1), t=0..7
    logic [4:0] exp8 [8];
    logic [15:0] stall_pat;
    int lane_cnt [5];

    spike_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pix_in      (pix_in),
        .num_steps   (num_steps),
        .busy        (busy),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .spikes      (spikes),
        .step_idx    (step_idx),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a frame and consume it; stall uses a fixed ready pattern, glitch
    // pulses start with different inputs at step 3
    task automatic run_frame(input int n, input bit stall, input bit glitch);
        int k = 0;
        int cyc = 0;
        logic [4:0] last_sp;
        logic [7:0] last_idx;
        bit stalled = 1'b0;
        for (int i = 0; i < 5; i++) lane_cnt[i] = 0;
        @(negedge clk);
        pix_in = PIX_A;
        num_steps = 8'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (k < n && cyc < 4 * n + 20) begin
            chk("valid", spike_valid, 1);
            chk("step_idx", step_idx, k);
            if (n == 8) chk("spikes8", spikes, exp8[k]);
            if (n == 1) chk("spikes1", spikes, 5'h00);
            if (stalled) begin
                chk("stall_spikes", spikes, last_sp);
                chk("stall_idx", step_idx, last_idx);
            end
            last_sp  = spikes;
            last_idx = step_idx;
            spike_ready = stall ? stall_pat[cyc % 16] : 1'b1;
            if (glitch && k == 3) begin
                start = 1'b1;
                pix_in = {40{1'b1}};
                num_steps = 8'd2;
            end else begin
                start = 1'b0;
                pix_in = PIX_A;
                num_steps = 8'(n);
            end
            @(negedge clk);
            stalled = !spike_ready;
            if (spike_ready) begin
                for (int i = 0; i < 5; i++) lane_cnt[i] += int'(last_sp[i]);
                k++;
            end
            cyc++;
        end
        start = 1'b0;
        spike_ready = 1'b1;
        chk("xfers", k, n);
        chk("done_pulse", done, 1);
        chk("fin_valid", spike_valid, 0);
        chk("fin_busy", busy, 0);
        @(negedge clk);
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        exp8[0] = 5'h00; exp8[1] = 5'h0C; exp8[2] = 5'h08; exp8[3] = 5'h0E;
        exp8[4] = 5'h08; exp8[5] = 5'h0C; exp8[6] = 5'h08; exp8[7] = 5'h0E;
        stall_pat = 16'b1001_0110_1100_1001;

        rst_n = 1'b0;
        start = 1'b0;
        pix_in = 40'd0;
        num_steps = 8'd0;
        spike_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", spike_valid, 0);
        chk("rst_spikes", spikes, 0);
        chk("rst_idx", step_idx, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;

        // Basic 8-step frame, ready held high
        run_frame(8, 1'b0, 1'b0);
        chk("cnt8_l1", lane_cnt[1], 2);
        chk("cnt8_l2", lane_cnt[2], 4);
        chk("cnt8_l3", lane_cnt[3], 7);

        // Long frame totals, then a one-step frame from cleared accumulators
        run_frame(255, 1'b0, 1'b0);
        chk("cnt255_l0", lane_cnt[0], 0);
        chk("cnt255_l1", lane_cnt[1], 63);
        chk("cnt255_l2", lane_cnt[2], 127);
        chk("cnt255_l3", lane_cnt[3], 254);
        chk("cnt255_l4", lane_cnt[4], 0);
        run_frame(1, 1'b0, 1'b0);

        // Back-pressure: same sequence, stable during stalls
        run_frame(8, 1'b1, 1'b0);

        // Zero-length frame
        @(negedge clk);
        num_steps = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("z_done", done, 1);
        chk("z_valid", spike_valid, 0);
        @(negedge clk);
        chk("z_done_clear", done, 0);
        chk("z_valid2", spike_valid, 0);
        chk("z_busy", busy, 0);

        // Reset in the middle of a 10-step frame
        @(negedge clk);
        pix_in = PIX_A;
        num_steps = 8'd10;
        spike_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_idx", step_idx, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", spike_valid, 0);
        chk("arst_spikes", spikes, 0);
        chk("arst_idx", step_idx, 0);
        chk("arst_done", done, 0);
        repeat (2) begin
            @(negedge clk);
            chk("arst_nodone", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);
        run_frame(8, 1'b0, 1'b0);

        // start during RUN with different inputs is ignored
        run_frame(8, 1'b0, 1'b1);
        @(negedge clk);
        chk("glitch_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
